// File: rtl/can_pkg.sv
// Shared CAN constants, transmitter state encoding and the CRC-15 step function.
package can_pkg;

  localparam int CAN_ID_W      = 11;
  localparam int CAN_DLC_W     = 4;
  localparam int CAN_CRC_W     = 15;
  localparam int CAN_EOF_LEN   = 7;
  localparam int CAN_MAX_BYTES = 8;

  localparam logic [CAN_CRC_W-1:0] CAN_CRC15_POLY = 15'h4599;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SOF,
    ST_ID,
    ST_DLC,
    ST_DATA,
    ST_CRC,
    ST_CRC_DEL,
    ST_ACK,
    ST_ACK_DEL,
    ST_EOF
  } can_tx_state_e;

  function automatic logic [CAN_CRC_W-1:0] crc15_step(input logic [CAN_CRC_W-1:0] crc,
                                                       input logic                 bit_in);
    logic fb;
    fb = bit_in ^ crc[CAN_CRC_W-1];
    return {crc[CAN_CRC_W-2:0], 1'b0} ^ (fb ? CAN_CRC15_POLY : '0);
  endfunction

endpackage

// File: rtl/can_crc15.sv
// Serial CRC-15/CAN register; clr wins over en. Shared between the TX and RX ends.
module can_crc15
  import can_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic                 bit_in,
  output logic [CAN_CRC_W-1:0] crc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      crc <= '0;
    else if (clr) crc <= '0;
    else if (en)  crc <= crc15_step(crc, bit_in);
  end

endmodule

// File: rtl/can_frame_transmitter.sv
// CAN frame transmitter: serializes one request per accept, one bit per bit_en strobe,
// with ID arbitration, readback bit-error detection and ACK slot sampling.
//
// state      | meaning
// IDLE       | waiting for tx_req, tx_bus recessive
// SOF        | start-of-frame dominant bit
// ID         | 11 identifier bits, arbitration active
// DLC        | 4 data length code bits (raw)
// DATA       | min(dlc,8) payload bytes
// CRC        | 15 CRC bits
// CRC_DEL    | CRC delimiter
// ACK        | ACK slot, recessive driven, rx sampled
// ACK_DEL    | ACK delimiter
// EOF        | 7 recessive end-of-frame bits
module can_frame_transmitter
  import can_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bit_en,
  input  logic                 tx_req,
  input  logic [CAN_ID_W-1:0]  tx_id,
  input  logic [CAN_DLC_W-1:0] tx_dlc,
  input  logic [63:0]          tx_data,
  input  logic                 rx_bus,
  output logic                 tx_bus,
  output logic                 busy,
  output logic                 tx_done,
  output logic                 ack_received,
  output logic                 arb_lost,
  output logic                 bit_error
);

  can_tx_state_e        state, state_nx;
  logic [6:0]           bit_cnt, cnt_nx;
  logic [CAN_ID_W-1:0]  id_r;
  logic [CAN_DLC_W-1:0] dlc_r;
  logic [3:0]           nbytes;
  logic [63:0]          data_sr, data_nx;
  logic                 tx_nx, busy_nx, ack_nx, done_nx, arb_nx, err_nx;
  logic                 accept, crc_clr, crc_en, mismatch;
  logic [CAN_CRC_W-1:0] crc, crc_nx;

  can_crc15 u_crc (
    .clk    (clk),
    .rst    (rst),
    .clr    (crc_clr),
    .en     (crc_en),
    .bit_in (tx_bus),
    .crc    (crc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      bit_cnt      <= '0;
      data_sr      <= '0;
      tx_bus       <= 1'b1;
      busy         <= 1'b0;
      ack_received <= 1'b0;
      tx_done      <= 1'b0;
      arb_lost     <= 1'b0;
      bit_error    <= 1'b0;
    end else begin
      state        <= state_nx;
      bit_cnt      <= cnt_nx;
      data_sr      <= data_nx;
      tx_bus       <= tx_nx;
      busy         <= busy_nx;
      ack_received <= ack_nx;
      tx_done      <= done_nx;
      arb_lost     <= arb_nx;
      bit_error    <= err_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_r   <= '0;
      dlc_r  <= '0;
      nbytes <= '0;
    end else if (accept) begin
      id_r   <= tx_id;
      dlc_r  <= tx_dlc;
      nbytes <= (tx_dlc > 4'(CAN_MAX_BYTES)) ? 4'(CAN_MAX_BYTES) : tx_dlc;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = bit_cnt;
    data_nx  = data_sr;
    tx_nx    = tx_bus;
    busy_nx  = busy;
    ack_nx   = ack_received;
    done_nx  = 1'b0;
    arb_nx   = 1'b0;
    err_nx   = 1'b0;
    accept   = 1'b0;
    crc_clr  = 1'b0;
    crc_en   = 1'b0;
    mismatch = rx_bus ^ tx_bus;
    // CRC including the bit on the wire now, needed for the first CRC bit
    crc_nx   = crc15_step(crc, tx_bus);

    if (state == ST_IDLE) begin
      if (tx_req) begin
        accept   = 1'b1;
        crc_clr  = 1'b1;
        state_nx = ST_SOF;
        tx_nx    = 1'b0;
        busy_nx  = 1'b1;
        ack_nx   = 1'b0;
        data_nx  = tx_data;
      end
    end else if (bit_en) begin
      crc_en = state inside {ST_SOF, ST_ID, ST_DLC, ST_DATA};
      case (state)
        ST_SOF: begin
          state_nx = ST_ID;
          cnt_nx   = 7'(CAN_ID_W - 1);
          tx_nx    = id_r[CAN_ID_W-1];
        end
        ST_ID: begin
          if (bit_cnt == '0) begin
            state_nx = ST_DLC;
            cnt_nx   = 7'(CAN_DLC_W - 1);
            tx_nx    = dlc_r[CAN_DLC_W-1];
          end else begin
            cnt_nx = bit_cnt - 7'd1;
            tx_nx  = id_r[bit_cnt[3:0] - 4'd1];
          end
        end
        ST_DLC: begin
          if (bit_cnt != '0) begin
            cnt_nx = bit_cnt - 7'd1;
            tx_nx  = dlc_r[bit_cnt[1:0] - 2'd1];
          end else if (nbytes == '0) begin
            state_nx = ST_CRC;
            cnt_nx   = 7'(CAN_CRC_W - 1);
            tx_nx    = crc_nx[CAN_CRC_W-1];
          end else begin
            state_nx = ST_DATA;
            cnt_nx   = {nbytes, 3'b000} - 7'd1;
            tx_nx    = data_sr[63];
          end
        end
        ST_DATA: begin
          data_nx = {data_sr[62:0], 1'b0};
          if (bit_cnt == '0) begin
            state_nx = ST_CRC;
            cnt_nx   = 7'(CAN_CRC_W - 1);
            tx_nx    = crc_nx[CAN_CRC_W-1];
          end else begin
            cnt_nx = bit_cnt - 7'd1;
            tx_nx  = data_sr[62];
          end
        end
        ST_CRC: begin
          if (bit_cnt == '0) begin
            state_nx = ST_CRC_DEL;
            tx_nx    = 1'b1;
          end else begin
            cnt_nx = bit_cnt - 7'd1;
            tx_nx  = crc[bit_cnt[3:0] - 4'd1];
          end
        end
        ST_CRC_DEL: begin
          state_nx = ST_ACK;
          tx_nx    = 1'b1;
        end
        ST_ACK: begin
          state_nx = ST_ACK_DEL;
          ack_nx   = ~rx_bus;
          tx_nx    = 1'b1;
        end
        ST_ACK_DEL: begin
          state_nx = ST_EOF;
          cnt_nx   = 7'(CAN_EOF_LEN - 1);
          tx_nx    = 1'b1;
        end
        ST_EOF: begin
          tx_nx = 1'b1;
          if (bit_cnt == '0) begin
            state_nx = ST_IDLE;
            busy_nx  = 1'b0;
            done_nx  = 1'b1;
          end else begin
            cnt_nx = bit_cnt - 7'd1;
          end
        end
        default: state_nx = ST_IDLE;
      endcase

      // Losing arbitration and readback errors abort the frame; both override completion
      if (state == ST_ID && tx_bus && !rx_bus) begin
        state_nx = ST_IDLE;
        tx_nx    = 1'b1;
        busy_nx  = 1'b0;
        done_nx  = 1'b0;
        arb_nx   = 1'b1;
      end else if (mismatch && state != ST_ACK) begin
        state_nx = ST_IDLE;
        tx_nx    = 1'b1;
        busy_nx  = 1'b0;
        done_nx  = 1'b0;
        err_nx   = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_can_frame_transmitter.sv
// Directed bench for can_frame_transmitter: captures each transmitted bit and compares
// against a bench-built reference frame with hand-chosen expected values.
module tb_can_frame_transmitter;

  logic        clk = 1'b0;
  logic        rst, bit_en, tx_req, rx_bus;
  logic [10:0] tx_id;
  logic [3:0]  tx_dlc;
  logic [63:0] tx_data;
  logic        tx_bus, busy, tx_done, ack_received, arb_lost, bit_error;
  logic        rx_ovr, rx_val;

  // Loopback unless a test forces the bus (second node / ACK / fault injection)
  assign rx_bus = rx_ovr ? rx_val : tx_bus;

  can_frame_transmitter dut (
    .clk          (clk),
    .rst          (rst),
    .bit_en       (bit_en),
    .tx_req       (tx_req),
    .tx_id        (tx_id),
    .tx_dlc       (tx_dlc),
    .tx_data      (tx_data),
    .rx_bus       (rx_bus),
    .tx_bus       (tx_bus),
    .busy         (busy),
    .tx_done      (tx_done),
    .ack_received (ack_received),
    .arb_lost     (arb_lost),
    .bit_error    (bit_error)
  );

  always #5 clk = ~clk;

  int          n_chk = 0, n_err = 0;
  logic        cap   [0:127];
  logic        exp_b [0:127];
  int          exp_len;
  logic [14:0] exp_crc;
  int          ack_idx = -1, arb_from = -1, err_idx = -1, req_idx = -1;
  int          n_str, done_at, arb_at, err_at, clk_cnt;
  int          stop;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic build_exp(input logic [10:0] id, input logic [3:0] dlc, input logic [63:0] data);
    int n, k;
    logic fb;
    n = (dlc > 4'd8) ? 8 : int'(dlc);
    k = 0;
    exp_b[k] = 1'b0; k++;
    for (int i = 10; i >= 0; i--) begin exp_b[k] = id[i]; k++; end
    for (int i = 3; i >= 0; i--) begin exp_b[k] = dlc[i]; k++; end
    for (int i = 0; i < 8 * n; i++) begin exp_b[k] = data[63 - i]; k++; end
    exp_crc = '0;
    for (int i = 0; i < k; i++) begin
      fb      = exp_b[i] ^ exp_crc[14];
      exp_crc = {exp_crc[13:0], 1'b0};
      if (fb) exp_crc = exp_crc ^ 15'h4599;
    end
    for (int i = 14; i >= 0; i--) begin exp_b[k] = exp_crc[i]; k++; end
    for (int i = 0; i < 10; i++) begin exp_b[k] = 1'b1; k++; end
    exp_len = k;
  endtask

  function automatic logic [63:0] field(input int start, input int width);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < width; i++) v = {v[62:0], cap[start + i]};
    return v;
  endfunction

  task automatic cmp_frame(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < exp_len; i++) if (cap[i] !== exp_b[i]) bad++;
    chk(tag, bad, 0);
  endtask

  task automatic start(input logic [10:0] id, input logic [3:0] dlc, input logic [63:0] data,
                       input logic en_on_accept);
    tx_id   = id;
    tx_dlc  = dlc;
    tx_data = data;
    tx_req  = 1'b1;
    bit_en  = en_on_accept;
    @(negedge clk);
    tx_req  = 1'b0;
    bit_en  = 1'b0;
  endtask

  task automatic run(input int period, input int max_str);
    n_str = 0; done_at = -1; arb_at = -1; err_at = -1; clk_cnt = 0;
    for (int s = 0; s < max_str && s < 128 && busy; s++) begin
      repeat (period - 1) begin @(negedge clk); clk_cnt++; end
      cap[s] = tx_bus;
      rx_ovr = 1'b0;
      rx_val = 1'b1;
      if (arb_from >= 0 && s >= arb_from) begin rx_ovr = 1'b1; rx_val = 1'b0; end
      if (s == ack_idx) begin rx_ovr = 1'b1; rx_val = 1'b0; end
      if (s == err_idx) begin rx_ovr = 1'b1; rx_val = 1'b1; end
      if (s == req_idx) tx_req = 1'b1;
      bit_en = 1'b1;
      @(negedge clk);
      clk_cnt++;
      bit_en = 1'b0;
      tx_req = 1'b0;
      rx_ovr = 1'b0;
      n_str  = s + 1;
      if (tx_done)   done_at = s + 1;
      if (arb_lost)  arb_at  = s + 1;
      if (bit_error) err_at  = s + 1;
    end
  endtask

  initial begin
    rst = 1'b1; bit_en = 1'b0; tx_req = 1'b0; rx_ovr = 1'b0; rx_val = 1'b1;
    tx_id = '0; tx_dlc = '0; tx_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_tx_bus", tx_bus, 1);
    chk("rst_busy", busy, 0);
    chk("rst_pulses", {tx_done, arb_lost, bit_error, ack_received}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Minimal frame, bit_en also high on the accept cycle
    start(11'h000, 4'd0, 64'd0, 1'b1);
    chk("t1_sof", tx_bus, 0);
    chk("t1_busy", busy, 1);
    build_exp(11'h000, 4'd0, 64'd0);
    run(1, 128);
    chk("t1_len", n_str, 41);
    chk("t1_done_at", done_at, 41);
    chk("t1_crc", field(16, 15), 15'h0000);
    cmp_frame("t1_bits");
    chk("t1_ack", ack_received, 0);
    chk("t1_idle", {busy, tx_bus, arb_lost, bit_error}, 4'b0100);
    @(negedge clk);
    chk("t1_done_1cyc", tx_done, 0);

    // All-recessive ID with one data byte, ACK given by a receiver
    ack_idx = 40;
    start(11'h7FF, 4'd1, {8'hA5, 56'd0}, 1'b0);
    build_exp(11'h7FF, 4'd1, {8'hA5, 56'd0});
    run(1, 128);
    ack_idx = -1;
    chk("t2_len", n_str, 49);
    chk("t2_done_at", done_at, 49);
    chk("t2_data", field(16, 8), 8'hA5);
    chk("t2_crc", field(24, 15), exp_crc);
    cmp_frame("t2_bits");
    chk("t2_ack", ack_received, 1);

    // Arbitration lost on ID bit 10
    arb_from = 1;
    start(11'h400, 4'd0, 64'd0, 1'b0);
    run(1, 128);
    arb_from = -1;
    chk("t3_arb_at", arb_at, 2);
    chk("t3_len", n_str, 2);
    chk("t3_state", {busy, tx_bus}, 2'b01);
    chk("t3_no_err", err_at, -1);
    chk("t3_no_done", done_at, -1);
    @(negedge clk);
    chk("t3_arb_1cyc", arb_lost, 0);

    // DLC 15, slow bit rate
    start(11'h555, 4'hF, 64'h0123_4567_89AB_CDEF, 1'b0);
    build_exp(11'h555, 4'hF, 64'h0123_4567_89AB_CDEF);
    run(4, 128);
    chk("t4_len", n_str, 105);
    chk("t4_done_at", done_at, 105);
    chk("t4_clocks", clk_cnt, 420);
    chk("t4_dlc", field(12, 4), 4'hF);
    chk("t4_data", field(16, 64), 64'h0123_4567_89AB_CDEF);
    cmp_frame("t4_bits");

    // Bit error mid-DATA; an in-frame request with another ID must be ignored
    err_idx = 17;
    req_idx = 5;
    start(11'h123, 4'd2, {16'h0F3C, 48'd0}, 1'b0);
    tx_id = 11'h7FF;
    run(1, 128);
    err_idx = -1;
    req_idx = -1;
    chk("t5_err_at", err_at, 18);
    chk("t5_state", {busy, tx_bus}, 2'b01);
    chk("t5_no_done", done_at, -1);
    chk("t5_no_arb", arb_at, -1);
    chk("t5_id_kept", field(1, 11), 11'h123);
    start(11'h2AA, 4'd0, 64'd0, 1'b0);
    chk("t5_reaccept", {busy, tx_bus}, 2'b10);
    build_exp(11'h2AA, 4'd0, 64'd0);
    run(1, 128);
    chk("t5_re_done_at", done_at, 41);
    cmp_frame("t5_re_bits");

    // Asynchronous reset while a dominant CRC bit is on the wire
    build_exp(11'h0F0, 4'd0, 64'd0);
    stop = 16;
    while (stop < 30 && exp_b[stop] != 1'b0) stop++;
    start(11'h0F0, 4'd0, 64'd0, 1'b0);
    run(1, stop);
    chk("t6_pre_rst", {busy, tx_bus}, 2'b10);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_async", {busy, tx_bus}, 2'b01);
    chk("t6_rst_pulses", {tx_done, arb_lost, bit_error}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start(11'h0F0, 4'd0, 64'd0, 1'b0);
    run(1, 128);
    chk("t6_done_at", done_at, 41);
    cmp_frame("t6_bits");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
